// File: rtl/pc_shift_accumulator_if.sv
// Control/data bundle for the PC/step accumulator: controls and adder operand in,
// register contents and combinational sum/carry out.
interface pc_shift_accumulator_if #(
  parameter int unsigned N = 64
);
  logic         Enable;
  logic         Load;
  logic         Dir;
  logic         LeftInput;
  logic         RightInput;
  logic         Cin;
  logic [N-1:0] Increment;
  logic [N-1:0] Q;
  logic [N-1:0] Sum;
  logic         Cout;

  modport master (
    output Enable, Load, Dir, LeftInput, RightInput, Cin, Increment,
    input  Q, Sum, Cout
  );

  modport slave (
    input  Enable, Load, Dir, LeftInput, RightInput, Cin, Increment,
    output Q, Sum, Cout
  );
endinterface

// File: rtl/pc_shift_accumulator.sv
// N-bit register fed by its own ripple-carry sum (Q + Increment + Cin),
// with left/right serial-fill shifting and hold; Sum/Cout are combinational from Q.
module pc_shift_accumulator #(
  parameter int unsigned N = 64
) (
  input  logic                    Clock,
  input  logic                    Reset,
  pc_shift_accumulator_if.slave   bus
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_sum;
  logic         w_carry;
  logic         w_cout;

  // Chained full adders: carry ripples from Cin through every bit position.
  always_comb begin : ripple_adder
    w_sum   = '0;
    w_carry = bus.Cin;
    for (int i = 0; i < int'(N); i++) begin
      w_sum[i] = r_q[i] ^ bus.Increment[i] ^ w_carry;
      w_carry  = (r_q[i] & bus.Increment[i]) | (w_carry & (r_q[i] ^ bus.Increment[i]));
    end
    w_cout = w_carry;
  end

  // Reset > Load > shift > hold; the shifted-out bit is dropped.
  always_ff @(posedge Clock) begin : shift_reg
    if (!Reset) begin
      r_q <= '0;
    end else if (bus.Load) begin
      r_q <= w_sum;
    end else if (bus.Enable) begin
      if (bus.Dir) begin
        r_q <= {r_q[N-2:0], bus.RightInput};
      end else begin
        r_q <= {bus.LeftInput, r_q[N-1:1]};
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.Sum  = w_sum;
  assign bus.Cout = w_cout;

endmodule

// File: tb/tb_pc_shift_accumulator.sv
// Directed-vector bench: driver pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against Q/Sum/Cout.
module tb_pc_shift_accumulator;

  localparam int unsigned N = 64;

  typedef struct {
    string        name;
    logic [N-1:0] q;
    logic [N-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  pc_shift_accumulator_if #(.N(N)) bus ();

  pc_shift_accumulator #(.N(N)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's controls, then queue the state expected after the edge.
  task automatic apply(input logic rst, input logic ld, input logic en, input logic dir,
                       input logic li, input logic ri, input logic ci,
                       input logic [N-1:0] inc, input logic [N-1:0] eq,
                       input logic [N-1:0] es, input logic ec, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n          = rst;
    bus.Load       = ld;
    bus.Enable     = en;
    bus.Dir        = dir;
    bus.LeftInput  = li;
    bus.RightInput = ri;
    bus.Cin        = ci;
    bus.Increment  = inc;
    @(posedge clk);
    #1;
    e.name = nm;
    e.q    = eq;
    e.sum  = es;
    e.cout = ec;
    sb.push_back(e);
  endtask

  // Inputs stay stable until after this negedge, so Sum/Cout match the queued row.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.Q !== e.q) begin
        n_fail++;
        $display("FAIL %s.q: got %h expected %h", e.name, bus.Q, e.q);
      end
      n_cmp++;
      if (bus.Sum !== e.sum) begin
        n_fail++;
        $display("FAIL %s.sum: got %h expected %h", e.name, bus.Sum, e.sum);
      end
      n_cmp++;
      if (bus.Cout !== e.cout) begin
        n_fail++;
        $display("FAIL %s.cout: got %b expected %b", e.name, bus.Cout, e.cout);
      end
    end
  end

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b1;
    bus.Load       = 1'b0;
    bus.Enable     = 1'b0;
    bus.Dir        = 1'b0;
    bus.LeftInput  = 1'b0;
    bus.RightInput = 1'b0;
    bus.Cin        = 1'b0;
    bus.Increment  = '0;

    //     rst   ld    en    dir   li    ri    cin   inc       expQ      expSum    cout
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd0,    64'd8,    1'b0, "reset0");
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd0,    64'd8,    1'b0, "reset1");
    for (int k = 1; k <= 11; k++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,
            64'(8 * k), 64'(8 * k + 8), 1'b0, $sformatf("accum%0d", k));
    end
    // Load Q = 88 + (2^64-96) = 2^64-8.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFA0,
          64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FF98, 1'b1, "to_top");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,
          64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, "wrap_sum");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd0,    64'd8,    1'b0, "wrap_q");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd8,    64'd9,    64'h12,   1'b0, "cin");
    // Shift left from 8 with RightInput=1.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd0,    64'd8,    1'b0, "rst_a");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd8,    64'd16,   1'b0, "ld8_a");
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd8,    64'h11,   64'h19,   1'b0, "shl");
    // Shift right from 8 with LeftInput=1.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd0,    64'd8,    1'b0, "rst_b");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd8,    64'd16,   1'b0, "ld8_b");
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd8,
          64'h8000_0000_0000_0004, 64'h8000_0000_0000_000C, 1'b0, "shr");
    // Load beats a requested shift.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd8,
          64'h8000_0000_0000_000C, 64'h8000_0000_0000_0014, 1'b0, "ld_over_sh");
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'(k), 1'(k + 1), 1'(k), 1'b0, 64'd8,
            64'h8000_0000_0000_000C, 64'h8000_0000_0000_0014, 1'b0, $sformatf("hold%0d", k));
    end
    // MSB falls off on a left shift.
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd8,    64'h18,   64'h20,   1'b0, "shl_drop");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'h20,   64'h28,   1'b0, "accum_more");
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'd8,    64'd0,    64'd9,    1'b0, "rst_mid");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd8,    64'd0,    64'd8,    1'b0, "post_rst");

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
